// File: rtl/sram_allocator.sv
// Round-robin bank allocator. It binds one port request at a time to an SRAM bank by scanning one bank per cycle.
// Build with SRAM_AFFINITY_EN defined to prefer banks that already hold data for the same destination.
module sram_allocator #(
  parameter int NUM_PORTS = 16,
  parameter int NUM_SRAM  = 32,
  parameter int BLK_WORDS = 8,
  parameter int LEN_W     = 9,
  parameter int FREE_W    = 11
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_PORTS-1:0]                          req,
  input  logic [NUM_PORTS-1:0][LEN_W-1:0]               req_length,
  input  logic [NUM_PORTS-1:0][$clog2(NUM_PORTS)-1:0]   req_dest,
  input  logic [NUM_SRAM-1:0]                           locking,
  input  logic [NUM_SRAM-1:0][FREE_W-1:0]               free_space,
  input  logic [NUM_SRAM-1:0][NUM_PORTS-1:0][FREE_W-1:0] port_amount,
  output logic [NUM_PORTS-1:0]                          gnt,
  output logic [NUM_PORTS-1:0]                          fail,
  output logic [$clog2(NUM_SRAM)-1:0]                   gnt_sram,
  output logic [NUM_SRAM-1:0]                           lock_en,
  output logic                                          busy
);

  localparam int PW     = $clog2(NUM_PORTS);
  localparam int SW     = $clog2(NUM_SRAM);
  localparam int NEED_W = 7;

  typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic [PW-1:0]         port_q, port_d;
  logic [PW-1:0]         dest_q, dest_d;
  logic [NEED_W-1:0]     need_q, need_d;
  logic [SW-1:0]         idx_q, idx_d;
  logic                  best_valid_q, best_valid_d;
  logic [SW-1:0]         best_idx_q, best_idx_d;
  logic [FREE_W:0]       best_score_q, best_score_d;
  logic                  hold_q, hold_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]  fail_q, fail_d;
  logic [NUM_SRAM-1:0]   lock_q, lock_d;
  logic [SW-1:0]         gnt_sram_q, gnt_sram_d;

  logic                  pick_found;
  logic [PW-1:0]         pick_port;
  logic [FREE_W:0]       cand_score;
  logic                  cand_ok;
  logic                  cand_take;
  logic                  best_ok;

  // Packet length in words rounded up to whole ECC blocks; an empty packet still needs one block.
  function automatic logic [NEED_W-1:0] blocks_of(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(BLK_WORDS - 1);
    blocks_of = NEED_W'(sum / (LEN_W+1)'(BLK_WORDS));
    if (len == '0) blocks_of = NEED_W'(1);
  endfunction

  // First requesting port at or after rr_q, wrapping modulo NUM_PORTS.
  always_comb begin
    pick_found = 1'b0;
    pick_port  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!pick_found && req[rr_q + PW'(i)]) begin
        pick_found = 1'b1;
        pick_port  = rr_q + PW'(i);
      end
    end
  end

`ifdef SRAM_AFFINITY_EN
  assign cand_score = {port_amount[idx_q][dest_q] != '0, free_space[idx_q]};
`else
  assign cand_score = {1'b0, free_space[idx_q]};
  logic unused_port_amount;
  assign unused_port_amount = ^port_amount;
`endif

  assign cand_ok   = !locking[idx_q] && (free_space[idx_q] >= FREE_W'(need_q));
  assign cand_take = cand_ok && (!best_valid_q || cand_score > best_score_q);
  assign best_ok   = !locking[best_idx_q] && (free_space[best_idx_q] >= FREE_W'(need_q));

  // NOTE: every variable driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    port_d       = port_q;
    dest_d       = dest_q;
    need_d       = need_q;
    idx_d        = idx_q;
    best_valid_d = best_valid_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    gnt_sram_d   = gnt_sram_q;
    hold_d       = 1'b0;
    gnt_d        = '0;
    fail_d       = '0;
    lock_d       = '0;

    case (state_q)
      IDLE: begin
        // Skip the pulse cycle so the port just served cannot be picked on its still-high req.
        if (!hold_q && pick_found) begin
          port_d       = pick_port;
          dest_d       = req_dest[pick_port];
          need_d       = blocks_of(req_length[pick_port]);
          idx_d        = '0;
          best_valid_d = 1'b0;
          best_idx_d   = '0;
          best_score_d = '0;
          state_d      = SCAN;
        end
      end

      SCAN: begin
        if (!req[port_q]) begin
          state_d = IDLE;
        end else begin
          if (cand_take) begin
            best_valid_d = 1'b1;
            best_idx_d   = idx_q;
            best_score_d = cand_score;
          end
          if (idx_q == SW'(NUM_SRAM - 1)) begin
            if (best_valid_d) begin
              state_d = GRANT;
            end else begin
              fail_d[port_q] = 1'b1;
              rr_d           = port_q + PW'(1);
              hold_d         = 1'b1;
              state_d        = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      GRANT: begin
        if (!req[port_q]) begin
          state_d = IDLE;
        end else if (best_ok) begin
          gnt_d[port_q]      = 1'b1;
          lock_d[best_idx_q] = 1'b1;
          gnt_sram_d         = best_idx_q;
          rr_d               = port_q + PW'(1);
          hold_d             = 1'b1;
          state_d            = IDLE;
        end else begin
          // Bank changed under us since it was scanned: start over without telling the port.
          idx_d        = '0;
          best_valid_d = 1'b0;
          best_idx_d   = '0;
          best_score_d = '0;
          state_d      = SCAN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: every register is reset, including the scan bookkeeping, so a reset mid-transaction leaves no stale pulse or winner.
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      port_q       <= '0;
      dest_q       <= '0;
      need_q       <= '0;
      idx_q        <= '0;
      best_valid_q <= 1'b0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      hold_q       <= 1'b0;
      gnt_q        <= '0;
      fail_q       <= '0;
      lock_q       <= '0;
      gnt_sram_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      port_q       <= port_d;
      dest_q       <= dest_d;
      need_q       <= need_d;
      idx_q        <= idx_d;
      best_valid_q <= best_valid_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      hold_q       <= hold_d;
      gnt_q        <= gnt_d;
      fail_q       <= fail_d;
      lock_q       <= lock_d;
      gnt_sram_q   <= gnt_sram_d;
    end
  end

  assign gnt      = gnt_q;
  assign fail     = fail_q;
  assign lock_en  = lock_q;
  assign gnt_sram = gnt_sram_q;
  assign busy     = (state_q != IDLE);

endmodule
